// File: rtl/uart_cmd_decoder.sv
// Decodes HEADER,ADDR,DH,DL[,CSUM] byte frames from a UART receiver into address/data commands.
// Latency: cmd_valid rises one cycle after the last byte capture. Backpressure: no bytes are unloaded while a command waits.
// Optional checksum byte enabled by defining CMD_CHECKSUM_EN.
module uart_cmd_decoder #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_rdy,
    input  logic [7:0]  rx_byte,
    output logic        uld_rx_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Expiry is flagged on the cycle whose increment would bring the count to TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DH,
        S_DL,
`ifdef CMD_CHECKSUM_EN
        S_CSUM,
`endif
        S_ISSUE
    } state_t;

    state_t         state_q, state_d;
    logic           fetch_q;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     dh_q, dh_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]     dl_q, dl_d;
    logic [7:0]     csum_sum;
`endif
    logic [7:0]     cmd_addr_q, cmd_addr_d;
    logic [15:0]    cmd_data_q, cmd_data_d;
    logic [7:0]     err_count_q, err_count_d;
    logic           err_c;
    logic           in_frame;

    assign in_frame    = (state_q != S_HDR) && (state_q != S_ISSUE);
    // The strobe is gated while a fetch is in flight, so rx_byte is always sampled exactly once.
    assign uld_rx_data = !reset && byte_rdy && !fetch_q && (state_q != S_ISSUE);
`ifdef CMD_CHECKSUM_EN
    assign csum_sum    = addr_q + dh_q + dl_q + rx_byte;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            fetch_q     <= 1'b0;
            timer_q     <= '0;
            addr_q      <= 8'h00;
            dh_q        <= 8'h00;
`ifdef CMD_CHECKSUM_EN
            dl_q        <= 8'h00;
`endif
            cmd_addr_q  <= 8'h00;
            cmd_data_q  <= 16'h0000;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            fetch_q     <= uld_rx_data;
            timer_q     <= timer_d;
            addr_q      <= addr_d;
            dh_q        <= dh_d;
`ifdef CMD_CHECKSUM_EN
            dl_q        <= dl_d;
`endif
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        addr_d      = addr_q;
        dh_d        = dh_q;
`ifdef CMD_CHECKSUM_EN
        dl_d        = dl_q;
`endif
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_count_d = err_count_q;
        err_c       = 1'b0;

        if (in_frame) begin
            timer_d = fetch_q ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_HDR: begin
                if (fetch_q && (rx_byte == HEADER)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (fetch_q) begin
                    addr_d  = rx_byte;
                    state_d = S_DH;
                end
            end
            S_DH: begin
                if (fetch_q) begin
                    dh_d    = rx_byte;
                    state_d = S_DL;
                end
            end
            S_DL: begin
                if (fetch_q) begin
`ifdef CMD_CHECKSUM_EN
                    dl_d    = rx_byte;
                    state_d = S_CSUM;
`else
                    cmd_addr_d = addr_q;
                    cmd_data_d = {dh_q, rx_byte};
                    state_d    = S_ISSUE;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            S_CSUM: begin
                if (fetch_q) begin
                    if (csum_sum == 8'h00) begin
                        cmd_addr_d = addr_q;
                        cmd_data_d = {dh_q, dl_q};
                        state_d    = S_ISSUE;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
`endif
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase

        // A capture on the expiry cycle keeps the frame alive.
        if (in_frame && !fetch_q && (timer_q == TMO_LAST)) begin
            err_c = 1'b1;
        end

        if (err_c) begin
            state_d     = S_HDR;
            timer_d     = '0;
            err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
        end
    end

    assign cmd_valid = (state_q == S_ISSUE);
    assign busy      = (state_q != S_HDR);
    assign frame_err = err_c && !reset;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised and directed bench for uart_cmd_decoder against a frame-parsing reference model.
module tb_uart_cmd_decoder;

    localparam int         TMO = 64;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef CMD_CHECKSUM_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_rdy = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        cmd_ready = 1'b0;
    logic        uld_rx_data, cmd_valid, frame_err, busy;
    logic [7:0]  cmd_addr, err_count;
    logic [15:0] cmd_data;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.HEADER(HDR), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .rx_byte(rx_byte),
        .uld_rx_data(uld_rx_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  rxq[$];
    logic [7:0]  sent_q[$];
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    int cyc = 0, last_uld = 0, last_fe = 0, fe_cnt = 0, cv_cycles = 0;
    int uld_consec = 0, uld_issue = 0, stab_err = 0;
    bit uld_seen = 0, prev_uld = 0, prev_cv = 0, prev_hs = 0, rand_rdy = 0;
    logic [23:0] prev_cmd = '0;

    // One clock: observe outputs at the falling edge, then act as the receiver after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (uld_rx_data) begin
            if (prev_uld) uld_consec++;
            if (cmd_valid) uld_issue++;
            last_uld = cyc;
        end
        if (frame_err) begin
            fe_cnt++;
            last_fe = cyc;
        end
        if (cmd_valid) begin
            cv_cycles++;
            if (!prev_cv) chk("latency", cyc - last_uld, 2);
            else if (!prev_hs && ({cmd_addr, cmd_data} != prev_cmd)) stab_err++;
            if (cmd_ready) obs_q.push_back({cmd_addr, cmd_data});
        end
        prev_uld = uld_rx_data;
        prev_cv  = cmd_valid;
        prev_hs  = cmd_valid && cmd_ready;
        prev_cmd = {cmd_addr, cmd_data};
        uld_seen = uld_rx_data;
        @(posedge clk);
        #1;
        if (uld_seen && rxq.size() != 0) rx_byte = rxq.pop_front();
        byte_rdy = (rxq.size() != 0);
        if (rand_rdy) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        sent_q.push_back(b);
        byte_rdy = 1'b1;
    endtask

    task automatic send_body(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
`ifdef CMD_CHECKSUM_EN
        logic [7:0] s;
        s = a + dh + dl;
`endif
        push(a);
        push(dh);
        push(dl);
`ifdef CMD_CHECKSUM_EN
        push(8'h00 - s);
`endif
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
        push(HDR);
        send_body(a, dh, dl);
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic send_bad(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
        logic [7:0] s;
        s = a + dh + dl;
        push(HDR);
        push(a);
        push(dh);
        push(dl);
        push(8'h01 - s);
    endtask
`endif

    task automatic rst();
        reset = 1'b1;
        tick();
        rxq.delete();
        byte_rdy = 1'b0;
        tick();
        reset = 1'b0;
        sent_q.delete();
        obs_q.delete();
        fe_cnt = 0;
        cv_cycles = 0;
    endtask

    task automatic wait_cv(input string tag);
        int n = 0;
        while (!cmd_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(cmd_valid), 1);
    endtask

    task automatic wait_obs(input int n, input int bound, input string tag);
        int k = 0;
        while (obs_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk(tag, obs_q.size(), n);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int run = 0;
        int k = 0;
        while (run < 3 && k < bound) begin
            tick();
            k++;
            run = (rxq.size() == 0 && !busy && !uld_seen && !cmd_valid) ? run + 1 : 0;
        end
        chk(tag, 32'(run >= 3), 1);
    endtask

    task automatic wait_fe(input int target, input string tag);
        int k = 0;
        while (fe_cnt < target && k < TMO + 40) begin
            tick();
            k++;
        end
        chk(tag, fe_cnt, target);
    endtask

    function automatic logic [23:0] obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : 24'hxxxxxx;
    endfunction

    // Reference: scan the sent byte stream for headers and slice whole frames out of it.
    function automatic int build_model();
        int i = 0;
        int e = 0;
        exp_q.delete();
        while (i < sent_q.size()) begin
            if (sent_q[i] != HDR) begin
                i++;
            end else if (i + FL > sent_q.size()) begin
                break;
            end else begin
`ifdef CMD_CHECKSUM_EN
                int s;
                s = int'(sent_q[i+1]) + int'(sent_q[i+2]) + int'(sent_q[i+3]) + int'(sent_q[i+4]);
                if ((s % 256) == 0) exp_q.push_back({sent_q[i+1], sent_q[i+2], sent_q[i+3]});
                else e++;
`else
                exp_q.push_back({sent_q[i+1], sent_q[i+2], sent_q[i+3]});
`endif
                i += FL;
            end
        end
        return e;
    endfunction

    initial begin
        int cv_low;
        int ui0;
        int exp_err;
        int kind;
        logic [7:0] jb;

        rst();
        chk("rst_uld", 32'(uld_rx_data), 0);
        chk("rst_cv", 32'(cmd_valid), 0);
        chk("rst_fe", 32'(frame_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(cmd_addr), 0);
        chk("rst_data", 32'(cmd_data), 0);
        chk("rst_errcnt", 32'(err_count), 0);

        // Single valid frame with an always-ready consumer
        cmd_ready = 1'b1;
        send_frame(8'h12, 8'h34, 8'h56);
        wait_obs(1, 100, "vf_done");
        wait_idle(50, "vf_idle");
        chk("vf_cmd", 32'(obs_at(0)), 32'h123456);
        chk("vf_cv_cycles", cv_cycles, 1);
        chk("vf_fe", fe_cnt, 0);

`ifdef CMD_CHECKSUM_EN
        rst();
        send_bad(8'h12, 8'h34, 8'h56);
        wait_idle(100, "bc_idle");
        chk("bc_pulses", fe_cnt, 1);
        chk("bc_errcnt", 32'(err_count), 1);
        chk("bc_nocmd", cv_cycles, 0);
        chk("bc_busy", 32'(busy), 0);
`endif

        // Consumer stalls while the next header is already waiting in the receiver
        rst();
        cmd_ready = 1'b0;
        send_frame(8'h12, 8'h34, 8'h56);
        push(HDR);
        wait_cv("bp_cv");
        cv_low = 0;
        ui0 = uld_issue;
        repeat (100) begin
            tick();
            if (!cmd_valid) cv_low++;
        end
        chk("bp_held", cv_low, 0);
        chk("bp_uld", uld_issue - ui0, 0);
        chk("bp_pending", rxq.size(), 1);
        chk("bp_hold_cmd", 32'({cmd_addr, cmd_data}), 32'h123456);
        cmd_ready = 1'b1;
        send_body(8'h9A, 8'hBC, 8'hDE);
        wait_obs(2, 200, "bp_done");
        chk("bp_cmd2", 32'(obs_at(1)), 32'h9ABCDE);
        wait_idle(50, "bp_idle");
        chk("bp_retain", 32'({cmd_addr, cmd_data}), 32'h9ABCDE);

        // Reset while a command is pending drops it
        rst();
        cmd_ready = 1'b0;
        send_frame(8'h77, 8'h88, 8'h99);
        wait_cv("rv_cv");
        reset = 1'b1;
        tick();
        chk("rv_drop", 32'(cmd_valid), 0);
        chk("rv_addr", 32'(cmd_addr), 0);

        // Inter-byte timeout
        rst();
        cmd_ready = 1'b1;
        push(HDR);
        push(8'h12);
        wait_fe(1, "tmo_seen");
        chk("tmo_lat", last_fe - (last_uld + 1), TMO - 1);
        tick();
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_errcnt", 32'(err_count), 1);
        send_frame(8'h21, 8'h43, 8'h65);
        wait_obs(1, 100, "tmo_next");
        chk("tmo_cmd", 32'(obs_at(0)), 32'h214365);

        // Junk bytes, then reset in the middle of a frame
        rst();
        push(8'h00);
        push(8'hFF);
        push(HDR);
        push(8'h12);
        ui0 = 0;
        while (rxq.size() != 0 && ui0 < 50) begin
            tick();
            ui0++;
        end
        tick();
        chk("jr_pre_fe", fe_cnt, 0);
        chk("jr_busy", 32'(busy), 1);
        rst();
        send_frame(8'h01, 8'h02, 8'h03);
        wait_obs(1, 100, "jr_done");
        wait_idle(50, "jr_idle");
        chk("jr_cmd", 32'(obs_at(0)), 32'h010203);
        chk("jr_ncmd", obs_q.size(), 1);
        chk("jr_fe", fe_cnt, 0);
        chk("jr_errcnt", 32'(err_count), 0);

        // Error counter saturation
        rst();
        cmd_ready = 1'b1;
`ifdef CMD_CHECKSUM_EN
        repeat (260) send_bad(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_idle(260 * FL * 3 + 200, "sat_idle");
`else
        for (int i = 0; i < 260; i++) begin
            push(HDR);
            wait_fe(i + 1, "sat_step");
        end
        tick();
`endif
        chk("sat_cnt", 32'(err_count), 255);
        chk("sat_pulses", fe_cnt, 260);

        // Randomised traffic with a randomly stalling consumer
        rst();
        rand_rdy = 1'b1;
        repeat (60) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == HDR) jb = 8'h00;
                push(jb);
`ifdef CMD_CHECKSUM_EN
            end else if (kind == 1) begin
                send_bad(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
`endif
            end else begin
                send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(4000, "rnd_idle");
        rand_rdy = 1'b0;
        cmd_ready = 1'b1;
        exp_err = build_model();
        chk("rnd_ncmd", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("rnd_cmd", 32'(obs_at(i)), 32'(exp_q[i]));
        end
        chk("rnd_pulses", fe_cnt, exp_err);
        chk("rnd_errcnt", 32'(err_count), (exp_err > 255) ? 255 : exp_err);

        chk("uld_consecutive", uld_consec, 0);
        chk("uld_in_issue", uld_issue, 0);
        chk("cmd_stable", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter HEADER, 8'hA5, frame start byte.
REQ-002 Parameter TIMEOUT_CYCLES, 40000, maximum clk cycles allowed between captured bytes inside a frame (1 ms at 40 MHz).
REQ-003 The clock SHALL be clk, and reset SHALL be reset: synchronous, active-high.
REQ-004 Port `clk`  in  1  system clock.
REQ-005 Port `reset`  in  1  synchronous active-high reset.
REQ-006 Port `byte_rdy`  in  1  receiver has a byte pending.
REQ-007 Port `rx_byte`  in  8  receiver data output, valid the cycle after uld_rx_data.
REQ-008 Port `uld_rx_data`  out  1  one-cycle unload strobe to the receiver.
REQ-009 Port `cmd_valid`  out  1  decoded command available.
REQ-010 Port `cmd_ready`  in  1  consumer accepts the command.
REQ-011 Port `cmd_addr`  out  8  command address.
REQ-012 Port `cmd_data`  out  16  command data, first data byte is MSB.
REQ-013 Port `frame_err`  out  1  one-cycle pulse on a checksum or timeout failure.
REQ-014 Port `err_count`  out  8  saturating error counter.
REQ-015 Port `busy`  out  1  high whenever the FSM is not in S_HDR.

Function
REQ-016 The frame format SHALL be HEADER, ADDR, DH, DL, then CSUM (CSUM only as defined in Configuration).
REQ-017 FSM states SHALL be S_HDR, S_ADDR, S_DH, S_DL, S_CSUM, S_ISSUE.
REQ-018 Fetch rule, in every state except S_ISSUE:
- byte_rdy=1 with no fetch in flight -> uld_rx_data=1 for exactly one cycle.
- rx_byte is captured on the following cycle.
- byte_rdy is ignored during those two cycles.
REQ-019 uld_rx_data SHALL never be asserted on two consecutive cycles.
REQ-020 uld_rx_data SHALL never be asserted in S_ISSUE; this applies backpressure to the receiver.
REQ-021 S_HDR transitions:
- captured byte == HEADER -> S_ADDR.
- any other byte -> discarded, remain in S_HDR, no error.
REQ-022 Each capture SHALL advance S_ADDR -> S_DH -> S_DL, storing each byte.
REQ-023 Transitions out of S_DL and S_CSUM SHALL be as follows:
- S_DL -> S_CSUM.
- S_CSUM, (ADDR+DH+DL+CSUM) mod 256 == 0 -> S_ISSUE.
- S_CSUM, otherwise -> frame_err pulse, err_count increment, S_HDR.
REQ-024 In S_ISSUE, cmd_valid=1 with cmd_addr/cmd_data stable until a cycle with cmd_ready=1; that cycle completes the transfer, and the FSM enters S_HDR on the next cycle.
REQ-025 Latency SHALL be one cycle: cmd_valid rises the cycle after the last byte capture.
REQ-026 Inter-byte timer, active in S_ADDR through S_CSUM:
- clears on entry to S_ADDR and on every capture.
- increments each cycle otherwise.
- on reaching TIMEOUT_CYCLES-1 with no capture that cycle -> frame_err pulse, err_count increment, S_HDR, partial bytes discarded.
REQ-027 A capture in the same cycle as timer expiry SHALL take priority (no error).
REQ-028 The timer SHALL be held at zero in S_HDR and S_ISSUE.
REQ-029 err_count SHALL saturate at 255; frame_err SHALL still pulse when saturated.
REQ-030 cmd_addr and cmd_data SHALL retain the last issued values after the handshake.

Reset
REQ-031 reset SHALL force the following values:
- state S_HDR; timer 0.
- uld_rx_data, cmd_valid, frame_err, busy = 0.
- cmd_addr=8'h00, cmd_data=16'h0000, err_count=8'h00.
REQ-032 reset SHALL take priority over all other inputs.
REQ-033 reset mid-frame or mid-fetch SHALL discard the frame, and no frame_err SHALL be produced.
REQ-034 reset with cmd_valid=1 SHALL drop cmd_valid on the next cycle without a handshake.

Configuration
REQ-035 Macro CMD_CHECKSUM_EN defined: frames are 5 bytes, S_CSUM is present, and checksum failure produces an error as in REQ-023.
REQ-036 Macro CMD_CHECKSUM_EN undefined:
- frames are 4 bytes; S_CSUM is absent; S_DL capture -> S_ISSUE.
- frame_err arises only from timeout.

Verification
REQ-037 Valid frame (CMD_CHECKSUM_EN): A5 12 34 56 64, cmd_ready=1 -> one cmd_valid cycle, cmd_addr=12, cmd_data=3456, frame_err=0.
REQ-038 Bad checksum: A5 12 34 56 65 -> frame_err one pulse, err_count=1, no cmd_valid, busy=0 afterwards.
REQ-039 Backpressure: valid frame with cmd_ready=0 for 100 cycles while a new A5 is pending -> uld_rx_data stays 0 and cmd_valid is held; cmd_ready=1 -> the next frame is then decoded.
REQ-040 Timeout: A5 12, then silence for TIMEOUT_CYCLES -> frame_err pulse exactly TIMEOUT_CYCLES-1 cycles after the 12 capture; a subsequent valid frame decodes.
REQ-041 Junk and reset: bytes 00 FF then A5 12 with reset mid-frame, then a valid frame -> no error, one command output.
REQ-042 Saturation: 260 bad-checksum frames -> err_count=255, 260 frame_err pulses.
